// File: rtl/inst_postfix_gather_pkg.sv
// rtl/inst_postfix_gather_pkg.sv - shared constants, types and postfix decode for the postfix gatherer
package inst_postfix_gather_pkg;

   localparam int DEF_INST_WIDTH  = 40;
   localparam int DEF_MAX_PFX     = 3;
   localparam int DEF_PFX_PAYLOAD = DEF_INST_WIDTH - 7;
   localparam int DEF_NPFX_W      = $clog2(DEF_MAX_PFX + 1);

   localparam logic [6:0] PFX_OPCODE = 7'h7F;

   typedef logic [DEF_INST_WIDTH-1:0] inst_word_t;

   typedef struct packed {
      inst_word_t                              inst;
      logic [DEF_MAX_PFX*DEF_PFX_PAYLOAD-1:0]  imm;
      logic [DEF_NPFX_W-1:0]                   npfx;
      logic                                    ovf;
   } pfx_bundle_t;

   function automatic logic is_postfix(input logic [6:0] opcode);
      return opcode == PFX_OPCODE;
   endfunction

endpackage

// File: rtl/inst_postfix_gather_if.sv
// rtl/inst_postfix_gather_if.sv - FIFO read side plus decode-facing bundle handshake
interface inst_postfix_gather_if
   import inst_postfix_gather_pkg::*;
#(
   parameter int INST_WIDTH  = DEF_INST_WIDTH,
   parameter int MAX_PFX     = DEF_MAX_PFX,
   parameter int PFX_PAYLOAD = INST_WIDTH - 7,
   parameter int NPFX_W      = $clog2(MAX_PFX + 1)
) ();

   logic                           flush_en;
   logic                           fifo_empty;
   logic [INST_WIDTH-1:0]          fifo_value;
   logic                           fifo_dequeue_en;
   logic                           out_valid;
   logic                           out_ready;
   logic [INST_WIDTH-1:0]          out_inst;
   logic [MAX_PFX*PFX_PAYLOAD-1:0] out_imm;
   logic [NPFX_W-1:0]              out_npfx;
   logic                           out_pfx_ovf;
   logic                           orphan_drop;

   modport master (
      input  flush_en, fifo_empty, fifo_value, out_ready,
      output fifo_dequeue_en, out_valid, out_inst, out_imm, out_npfx, out_pfx_ovf, orphan_drop
   );

   modport slave (
      output flush_en, fifo_empty, fifo_value, out_ready,
      input  fifo_dequeue_en, out_valid, out_inst, out_imm, out_npfx, out_pfx_ovf, orphan_drop
   );

endinterface

// File: rtl/inst_postfix_gather_pfx_imm_fill.sv
// rtl/inst_postfix_gather_pfx_imm_fill.sv - sign-extends unused immediate slots from the last absorbed postfix
module pfx_imm_fill
   import inst_postfix_gather_pkg::*;
#(
   parameter int MAX_PFX     = DEF_MAX_PFX,
   parameter int PFX_PAYLOAD = DEF_PFX_PAYLOAD,
   parameter int NPFX_W      = $clog2(MAX_PFX + 1)
) (
   input  logic [MAX_PFX*PFX_PAYLOAD-1:0] raw,
   input  logic [NPFX_W-1:0]              npfx,
   output logic [MAX_PFX*PFX_PAYLOAD-1:0] filled
);

   logic sign;

   // With npfx == 0 no slot qualifies as "last", so sign stays 0 and the whole immediate is zero.
   always_comb begin
      sign   = 1'b0;
      filled = raw;
      for (int i = 0; i < MAX_PFX; i++) begin
         if (npfx == NPFX_W'(i + 1)) sign = raw[i*PFX_PAYLOAD + PFX_PAYLOAD - 1];
      end
      for (int i = 0; i < MAX_PFX; i++) begin
         if (npfx <= NPFX_W'(i)) filled[i*PFX_PAYLOAD +: PFX_PAYLOAD] = {PFX_PAYLOAD{sign}};
      end
   end

endmodule

// File: rtl/inst_postfix_gather.sv
// rtl/inst_postfix_gather.sv - pops instruction words, absorbs trailing postfixes, presents one bundle to decode
module inst_postfix_gather
   import inst_postfix_gather_pkg::*;
#(
   parameter int INST_WIDTH  = DEF_INST_WIDTH,
   parameter int MAX_PFX     = DEF_MAX_PFX,
   parameter int PFX_PAYLOAD = INST_WIDTH - 7,
   parameter int NPFX_W      = $clog2(MAX_PFX + 1)
) (
   input logic clk,
   input logic reset,
   inst_postfix_gather_if.master bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_OUT     = 2'd2;

   logic [1:0]                     state_q;
   logic [INST_WIDTH-1:0]          inst_q;
   logic [MAX_PFX*PFX_PAYLOAD-1:0] imm_q;
   logic [MAX_PFX*PFX_PAYLOAD-1:0] imm_filled;
   logic [NPFX_W-1:0]              npfx_q;
   logic                           ovf_q;
   logic                           orphan_q;
   logic                           head_pfx;
   logic                           at_max;
   logic                           dequeue;

   assign head_pfx = is_postfix(bus.fifo_value[6:0]);
   assign at_max   = (npfx_q == NPFX_W'(MAX_PFX));

   pfx_imm_fill #(
      .MAX_PFX     (MAX_PFX),
      .PFX_PAYLOAD (PFX_PAYLOAD),
      .NPFX_W      (NPFX_W)
   ) u_fill (
      .raw    (imm_q),
      .npfx   (npfx_q),
      .filled (imm_filled)
   );

   // A bundle only closes once the following word is visible, so COLLECT never pops the closing word.
   always_comb begin
      dequeue = 1'b0;
      if (!reset && !bus.flush_en && !bus.fifo_empty) begin
         case (state_q)
            S_IDLE:    dequeue = 1'b1;
            S_COLLECT: dequeue = head_pfx && !at_max;
            S_OUT:     dequeue = bus.out_ready && !head_pfx;
            default:   dequeue = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         inst_q   <= '0;
         imm_q    <= '0;
         npfx_q   <= '0;
         ovf_q    <= 1'b0;
         orphan_q <= 1'b0;
      end else begin
         orphan_q <= 1'b0;
         if (bus.flush_en) begin
            state_q <= S_IDLE;
            npfx_q  <= '0;
            ovf_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (dequeue) begin
                     if (head_pfx) begin
                        orphan_q <= 1'b1;
                     end else begin
                        inst_q  <= bus.fifo_value;
                        imm_q   <= '0;
                        npfx_q  <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_COLLECT;
                     end
                  end
               end
               S_COLLECT: begin
                  if (dequeue) begin
                     for (int i = 0; i < MAX_PFX; i++) begin
                        if (npfx_q == NPFX_W'(i))
                           imm_q[i*PFX_PAYLOAD +: PFX_PAYLOAD] <= bus.fifo_value[INST_WIDTH-1:7];
                     end
                     npfx_q <= npfx_q + 1'b1;
                  end else if (!bus.fifo_empty) begin
                     ovf_q   <= head_pfx;
                     imm_q   <= imm_filled;
                     state_q <= S_OUT;
                  end
               end
               S_OUT: begin
                  if (bus.out_ready) begin
                     if (dequeue) begin
                        inst_q  <= bus.fifo_value;
                        imm_q   <= '0;
                        npfx_q  <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_COLLECT;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.fifo_dequeue_en = dequeue;
   assign bus.out_valid       = (state_q == S_OUT);
   assign bus.out_inst        = inst_q;
   assign bus.out_imm         = imm_q;
   assign bus.out_npfx        = npfx_q;
   assign bus.out_pfx_ovf     = ovf_q;
   assign bus.orphan_drop     = orphan_q;

endmodule

// File: tb/tb_inst_postfix_gather.sv
// tb/tb_inst_postfix_gather.sv - directed table and sequence checks for inst_postfix_gather
module tb_inst_postfix_gather;
   import inst_postfix_gather_pkg::*;

   typedef struct {
      logic [39:0]      inst;
      int               np;
      logic [3:0][32:0] p;
      logic [1:0]       npfx;
      logic [98:0]      imm;
      logic             ovf;
      int               orphans;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   logic [39:0] mem [256];
   int          wr = 0;
   int          rd = 0;
   logic        pop_pending = 1'b0;
   int          viol = 0;
   int          orphan_cnt = 0;
   pfx_bundle_t got [$];

   inst_postfix_gather_if bus ();

   inst_postfix_gather dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.fifo_empty = (wr == rd);
   assign bus.fifo_value = (wr == rd) ? 40'h0 : mem[rd[7:0]];

   always @(posedge clk) begin
      pfx_bundle_t b;
      pop_pending <= bus.fifo_dequeue_en;
      if (bus.fifo_dequeue_en && bus.fifo_empty) viol++;
      if (bus.orphan_drop) orphan_cnt++;
      if (!reset && bus.out_valid && bus.out_ready) begin
         b.inst = bus.out_inst;
         b.imm  = bus.out_imm;
         b.npfx = bus.out_npfx;
         b.ovf  = bus.out_pfx_ovf;
         got.push_back(b);
      end
   end

   always @(negedge clk) if (pop_pending) rd++;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [39:0] w);
      mem[wr[7:0]] = w;
      wr++;
   endtask

   function automatic logic [39:0] mk_inst(input logic [32:0] tag);
      return {tag, 7'h02};
   endfunction

   function automatic logic [39:0] mk_pfx(input logic [32:0] payload);
      return {payload, PFX_OPCODE};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 30) begin
         step();
         n++;
      end
      check("wait_valid", bus.out_valid, 1);
   endtask

   task automatic do_flush();
      bus.flush_en = 1'b1;
      step();
      bus.flush_en = 1'b0;
   endtask

   vec_t        vt [6];
   logic [39:0] term;
   int          lat;
   int          gbase;
   int          obase;

   initial begin
      term = mk_inst(33'h1AAAA);
      vt[0] = '{mk_inst(33'h11), 0, '0, 2'd0, 99'h0, 1'b0, 0};
      vt[1] = '{mk_inst(33'h22), 2, '0, 2'd2,
                {33'h1_FFFF_FFFF, 33'h1_0000_0001, 33'h0_0000_00AB}, 1'b0, 0};
      vt[1].p[0] = 33'h0_0000_00AB;
      vt[1].p[1] = 33'h1_0000_0001;
      vt[2] = '{mk_inst(33'h33), 1, '0, 2'd1,
                {33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_2345_6789}, 1'b0, 0};
      vt[2].p[0] = 33'h1_2345_6789;
      vt[3] = '{mk_inst(33'h44), 1, '0, 2'd1, {66'h0, 33'h0_1234_5678}, 1'b0, 0};
      vt[3].p[0] = 33'h0_1234_5678;
      vt[4] = '{mk_inst(33'h55), 3, '0, 2'd3, {33'h2, 33'h1_0000_0000, 33'h1}, 1'b0, 0};
      vt[4].p[0] = 33'h1;
      vt[4].p[1] = 33'h1_0000_0000;
      vt[4].p[2] = 33'h2;
      vt[5] = '{mk_inst(33'h66), 4, '0, 2'd3, {33'h1_8000_0000, 33'h6, 33'h5}, 1'b1, 1};
      vt[5].p[0] = 33'h5;
      vt[5].p[1] = 33'h6;
      vt[5].p[2] = 33'h1_8000_0000;
      vt[5].p[3] = 33'h7;

      // Reset with a postfix already waiting: nothing may be popped until reset drops.
      reset = 1'b1;
      bus.flush_en = 1'b0;
      bus.out_ready = 1'b0;
      push(mk_pfx(33'h1));
      repeat (3) step();
      check("rst_valid", bus.out_valid, 0);
      check("rst_inst", bus.out_inst, 0);
      check("rst_imm", bus.out_imm, 0);
      check("rst_npfx", bus.out_npfx, 0);
      check("rst_ovf", bus.out_pfx_ovf, 0);
      check("rst_orphan", bus.orphan_drop, 0);
      check("rst_deq", bus.fifo_dequeue_en, 0);
      obase = orphan_cnt;
      reset = 1'b0;
      repeat (3) step();
      check("rst_orphan_cnt", orphan_cnt - obase, 1);
      check("rst_idle_valid", bus.out_valid, 0);

      bus.out_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         gbase = got.size();
         obase = orphan_cnt;
         push(vt[v].inst);
         for (int j = 0; j < vt[v].np; j++) push(mk_pfx(vt[v].p[j]));
         push(term);
         lat = 0;
         while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
         end
         check($sformatf("v%0d_latency", v), lat, 2 + int'(vt[v].npfx));
         check($sformatf("v%0d_deq_at_out", v), bus.fifo_dequeue_en, !vt[v].ovf);
         if (!vt[v].ovf) begin
            step();
            check($sformatf("v%0d_next_capture", v), bus.out_inst, term);
            repeat (7) step();
         end else begin
            repeat (8) step();
         end
         check($sformatf("v%0d_bundles", v), got.size() - gbase, 1);
         if (got.size() > gbase) begin
            check($sformatf("v%0d_inst", v), got[gbase].inst, vt[v].inst);
            check($sformatf("v%0d_imm", v), got[gbase].imm, vt[v].imm);
            check($sformatf("v%0d_npfx", v), got[gbase].npfx, vt[v].npfx);
            check($sformatf("v%0d_ovf", v), got[gbase].ovf, vt[v].ovf);
         end
         check($sformatf("v%0d_orphans", v), orphan_cnt - obase, vt[v].orphans);
         do_flush();
      end

      // Backpressure: bundle frozen for 5 cycles, then the next instruction pops on release.
      bus.out_ready = 1'b0;
      push(mk_inst(33'h100));
      push(mk_pfx(33'h3));
      push(mk_inst(33'h200));
      push(mk_inst(33'h300));
      wait_valid(lat);
      for (int c = 0; c < 5; c++) begin
         check("stall_valid", bus.out_valid, 1);
         check("stall_inst", bus.out_inst, mk_inst(33'h100));
         check("stall_imm", bus.out_imm, {66'h0, 33'h3});
         check("stall_npfx", bus.out_npfx, 1);
         check("stall_deq", bus.fifo_dequeue_en, 0);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_deq", bus.fifo_dequeue_en, 1);
      step();
      check("release_inst", bus.out_inst, mk_inst(33'h200));
      check("release_valid", bus.out_valid, 0);
      repeat (4) step();
      do_flush();

      // FIFO gap inside COLLECT: hold without popping until the closing word shows up.
      gbase = got.size();
      push(mk_inst(33'h400));
      push(mk_pfx(33'h9));
      step();
      step();
      for (int c = 0; c < 6; c++) begin
         check("gap_valid", bus.out_valid, 0);
         check("gap_deq", bus.fifo_dequeue_en, 0);
         step();
      end
      push(mk_inst(33'h500));
      lat = 0;
      while (!bus.out_valid && lat < 2) begin
         step();
         lat++;
      end
      check("gap_close_valid", bus.out_valid, 1);
      check("gap_close_npfx", bus.out_npfx, 1);
      check("gap_close_inst", bus.out_inst, mk_inst(33'h400));
      repeat (3) step();
      do_flush();

      // Flush in COLLECT with a postfix at the head: no pop, and the postfix becomes an orphan.
      push(mk_inst(33'h600));
      push(mk_pfx(33'h4));
      step();
      step();
      push(mk_pfx(33'h5));
      obase = orphan_cnt;
      bus.flush_en = 1'b1;
      #1;
      check("flush_col_deq", bus.fifo_dequeue_en, 0);
      step();
      bus.flush_en = 1'b0;
      check("flush_col_valid", bus.out_valid, 0);
      check("flush_col_npfx", bus.out_npfx, 0);
      gbase = got.size();
      push(mk_inst(33'h700));
      push(mk_inst(33'h800));
      wait_valid(lat);
      check("flush_col_orphan", orphan_cnt - obase, 1);
      check("flush_col_fresh_inst", bus.out_inst, mk_inst(33'h700));
      check("flush_col_fresh_npfx", bus.out_npfx, 0);
      repeat (3) step();
      do_flush();

      // Flush while an overflowed bundle waits in OUT.
      bus.out_ready = 1'b0;
      push(mk_inst(33'h900));
      for (int j = 0; j < 4; j++) push(mk_pfx(33'(j + 1)));
      wait_valid(lat);
      check("flush_out_pre_ovf", bus.out_pfx_ovf, 1);
      check("flush_out_pre_npfx", bus.out_npfx, 3);
      bus.flush_en = 1'b1;
      #1;
      check("flush_out_deq", bus.fifo_dequeue_en, 0);
      step();
      bus.flush_en = 1'b0;
      check("flush_out_valid", bus.out_valid, 0);
      check("flush_out_ovf", bus.out_pfx_ovf, 0);
      check("flush_out_npfx", bus.out_npfx, 0);
      bus.out_ready = 1'b1;
      obase = orphan_cnt;
      push(mk_inst(33'hA00));
      push(mk_inst(33'hB00));
      wait_valid(lat);
      check("after_ovf_orphan", orphan_cnt - obase, 1);
      check("after_ovf_inst", bus.out_inst, mk_inst(33'hA00));
      check("after_ovf_ovf", bus.out_pfx_ovf, 0);
      repeat (3) step();
      do_flush();

      // Reset while a bundle is presented.
      bus.out_ready = 1'b0;
      push(mk_inst(33'hC00));
      push(mk_pfx(33'h1_0000_0000));
      push(mk_inst(33'hD00));
      wait_valid(lat);
      reset = 1'b1;
      step();
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_inst", bus.out_inst, 0);
      check("midrst_imm", bus.out_imm, 0);
      check("midrst_npfx", bus.out_npfx, 0);
      reset = 1'b0;
      step();

      check("deq_while_empty", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=0", 1);
      $fatal(1);
   end

endmodule
